// File: rtl/instr_exec_ctrl_pkg.sv
// Shared definitions for the execute/control unit: opcodes, FSM encoding and
// instruction field widths.
package instr_exec_ctrl_pkg;

    localparam int INSTR_W = 16;
    localparam int OPC_W   = 4;
    localparam int REG_AW  = 4;
    localparam int IMM_W   = 4;

    localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OPC_W-1:0] OP_ADDI = 4'h1;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'h2;
    localparam logic [OPC_W-1:0] OP_AND  = 4'h3;
    localparam logic [OPC_W-1:0] OP_LW   = 4'h4;
    localparam logic [OPC_W-1:0] OP_SW   = 4'h5;
    localparam logic [OPC_W-1:0] OP_BNE  = 4'h6;
    localparam logic [OPC_W-1:0] OP_J    = 4'h7;
    localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    function automatic logic is_alu(input logic [OPC_W-1:0] op);
        return (op == OP_ADDI) || (op == OP_SUB) || (op == OP_AND);
    endfunction

endpackage

// File: rtl/instr_exec_ctrl_if.sv
// Instruction-memory and data-memory signals seen by the controller.
// The controller side is the master; the memories are the slave side.
interface instr_exec_ctrl_if #(
    parameter int DATA_W  = 16,
    parameter int DADDR_W = 8,
    parameter int PC_W    = 4
);
    logic [15:0]        instr_i;
    logic               next_o;
    logic               be_o;
    logic [PC_W-1:0]    branch_adr_o;
    logic               dmem_req_o;
    logic               dmem_we_o;
    logic [DADDR_W-1:0] dmem_addr_o;
    logic [DATA_W-1:0]  dmem_wdata_o;
    logic [DATA_W-1:0]  dmem_rdata_i;
    logic               dmem_ack_i;

    modport master (
        input  instr_i, dmem_rdata_i, dmem_ack_i,
        output next_o, be_o, branch_adr_o,
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o
    );

    modport slave (
        output instr_i, dmem_rdata_i, dmem_ack_i,
        input  next_o, be_o, branch_adr_o,
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o
    );
endinterface

// File: rtl/exec_regfile.sv
// Register file: two operand read ports, one debug read port, one synchronous
// write port. R0 always reads zero and ignores writes.
module exec_regfile #(
    parameter int  DATA_W = 16,
    parameter int  NREGS  = 16,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     ra1,
    input  logic [AW-1:0]     ra2,
    input  logic [AW-1:0]     dbg_ra,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] dbg_rd,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [DATA_W-1:0] wd
);
    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    assign rd1    = (ra1 == '0)    ? '0 : regs[ra1];
    assign rd2    = (ra2 == '0)    ? '0 : regs[ra2];
    assign dbg_rd = (dbg_ra == '0) ? '0 : regs[dbg_ra];

endmodule

// File: rtl/instr_exec_ctrl.sv
// Multi-cycle execute/control unit: decodes the instruction stream, runs it
// against the register file, and drives data-memory and PC-advance handshakes.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_FETCH  | latch instr_i into IR
//   S_DECODE | latch operands A/B from the register file
//   S_EXEC   | ALU write / branch / jump / start memory access / halt
//   S_MEM    | hold data-memory request until ack
//   S_WB     | write load data to R[rd]
//   S_HALT   | absorbing until reset
module instr_exec_ctrl
    import instr_exec_ctrl_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int DADDR_W = 8,
    parameter int PC_W    = 4,
    parameter int NREGS   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    instr_exec_ctrl_if.master bus,
    output logic              halted_o,
    output logic              illegal_o,
    input  logic [3:0]        dbg_raddr_i,
    output logic [DATA_W-1:0] dbg_rdata_o
);
    state_t               state;
    logic [INSTR_W-1:0]   ir;
    logic [DATA_W-1:0]    opa, opb, mdr;

    logic                 next_q, be_q, req_q, we_q;
    logic [PC_W-1:0]      badr_q;
    logic [DADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]    wdata_q;

    logic [OPC_W-1:0]     op;
    logic [REG_AW-1:0]    rd, rs, rt;
    logic [DATA_W-1:0]    imm_ext, alu_res, mem_base, rf_rd1, rf_rd2, rf_wd;
    logic [DADDR_W-1:0]   mem_addr;
    logic [REG_AW-1:0]    rf_ra1, rf_ra2;
    logic                 rf_we, cross_ops;

    assign op      = ir[15:12];
    assign rd      = ir[11:8];
    assign rs      = ir[7:4];
    assign rt      = ir[3:0];
    assign imm_ext = DATA_W'(rt);

    // BNE compares rd with rs, SW stores rd at rs+imm: both use rd as A and rs as B.
    assign cross_ops = (op == OP_BNE) || (op == OP_SW);
    assign rf_ra1    = cross_ops ? rd : rs;
    assign rf_ra2    = cross_ops ? rs : rt;

    always_comb begin
        alu_res = opa + imm_ext;
        case (op)
            OP_SUB:  alu_res = opa - opb;
            OP_AND:  alu_res = opa & opb;
            default: ;
        endcase
    end

    assign mem_base = (op == OP_SW) ? opb : opa;
    assign mem_addr = DADDR_W'(mem_base + imm_ext);

    assign rf_we = ((state == S_EXEC) && is_alu(op)) || (state == S_WB);
    assign rf_wd = (state == S_WB) ? mdr : alu_res;

    exec_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .ra1    (rf_ra1),
        .ra2    (rf_ra2),
        .dbg_ra (dbg_raddr_i),
        .rd1    (rf_rd1),
        .rd2    (rf_rd2),
        .dbg_rd (dbg_rdata_o),
        .we     (rf_we),
        .wa     (rd),
        .wd     (rf_wd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            ir        <= '0;
            opa       <= '0;
            opb       <= '0;
            mdr       <= '0;
            next_q    <= 1'b0;
            be_q      <= 1'b0;
            badr_q    <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            halted_o  <= 1'b0;
            illegal_o <= 1'b0;
        end else begin
            next_q <= 1'b0;
            be_q   <= 1'b0;
            case (state)
                S_FETCH: begin
                    ir    <= bus.instr_i;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    opa   <= rf_rd1;
                    opb   <= rf_rd2;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    case (op)
                        OP_NOP, OP_ADDI, OP_SUB, OP_AND: begin
                            next_q <= 1'b1;
                            state  <= S_FETCH;
                        end
                        OP_BNE: begin
                            next_q <= 1'b1;
                            be_q   <= (opa != opb);
                            badr_q <= PC_W'(rt);
                            state  <= S_FETCH;
                        end
                        OP_J: begin
                            next_q <= 1'b1;
                            be_q   <= 1'b1;
                            badr_q <= PC_W'(rt);
                            state  <= S_FETCH;
                        end
                        OP_LW: begin
                            req_q  <= 1'b1;
                            we_q   <= 1'b0;
                            addr_q <= mem_addr;
                            state  <= S_MEM;
                        end
                        OP_SW: begin
                            req_q   <= 1'b1;
                            we_q    <= 1'b1;
                            addr_q  <= mem_addr;
                            wdata_q <= opa;
                            state   <= S_MEM;
                        end
                        OP_HALT: begin
                            halted_o <= 1'b1;
                            state    <= S_HALT;
                        end
                        default: begin
                            illegal_o <= 1'b1;
                            next_q    <= 1'b1;
                            state     <= S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    if (bus.dmem_ack_i) begin
                        req_q <= 1'b0;
                        if (op == OP_SW) begin
                            next_q <= 1'b1;
                            state  <= S_FETCH;
                        end else begin
                            mdr   <= bus.dmem_rdata_i;
                            state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    next_q <= 1'b1;
                    state  <= S_FETCH;
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

    assign bus.next_o       = next_q;
    assign bus.be_o         = be_q;
    assign bus.branch_adr_o = badr_q;
    assign bus.dmem_req_o   = req_q;
    assign bus.dmem_we_o    = we_q;
    assign bus.dmem_addr_o  = addr_q;
    assign bus.dmem_wdata_o = wdata_q;

endmodule

// File: tb/tb_instr_exec_ctrl.sv
// Bench for instr_exec_ctrl: directed program plus random instructions, checked
// against an instruction-level model of registers, data memory and timing.
module tb_instr_exec_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  dbg_raddr;
    logic [15:0] dbg_rdata;
    logic        halted, illegal;

    instr_exec_ctrl_if bus ();

    instr_exec_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .halted_o    (halted),
        .illegal_o   (illegal),
        .dbg_raddr_i (dbg_raddr),
        .dbg_rdata_o (dbg_rdata)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] mr [16];
    logic [15:0] dm [256];
    bit          m_ill;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] enc(input int op, input int rd, input int rs, input int rt);
        return {4'(op), 4'(rd), 4'(rs), 4'(rt)};
    endfunction

    // Called at a negedge inside the FETCH cycle; returns at the FETCH cycle
    // of the next instruction.
    task automatic run_instr(input logic [15:0] ins, input int lat);
        logic [3:0]  op, rd, rs, rt;
        logic [15:0] res, sd;
        logic [7:0]  ea;
        bit          wr, is_mem, is_ld, exp_be, is_br, done, stray;
        int          exp_lat, cyc, reqc;
        op = ins[15:12]; rd = ins[11:8]; rs = ins[7:4]; rt = ins[3:0];
        wr = 0; is_mem = 0; is_ld = 0; exp_be = 0; is_br = 0;
        exp_lat = 3; res = '0; sd = '0; ea = '0;
        case (op)
            4'h1: begin res = mr[rs] + 16'(rt); wr = 1; end
            4'h2: begin res = mr[rs] - mr[rt];  wr = 1; end
            4'h3: begin res = mr[rs] & mr[rt];  wr = 1; end
            4'h4: begin
                ea = 8'(mr[rs] + 16'(rt)); is_mem = 1; is_ld = 1;
                exp_lat = 4 + lat; res = dm[ea]; wr = 1;
            end
            4'h5: begin
                ea = 8'(mr[rs] + 16'(rt)); is_mem = 1; sd = mr[rd];
                exp_lat = 3 + lat;
            end
            4'h6: begin is_br = 1; exp_be = (mr[rd] != mr[rs]); end
            4'h7: begin is_br = 1; exp_be = 1; end
            4'h0, 4'hF: ;
            default: m_ill = 1;
        endcase

        bus.instr_i = ins;
        cyc = 0; reqc = 0; done = 0; stray = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.dmem_req_o) begin
                reqc++;
                if (!is_mem) stray = 1;
                else begin
                    check("dmem_we_addr", 32'({bus.dmem_we_o, bus.dmem_addr_o}), 32'({!is_ld, ea}));
                    if (!is_ld) check("dmem_wdata", 32'(bus.dmem_wdata_o), 32'(sd));
                end
                bus.dmem_ack_i   = (reqc == lat);
                bus.dmem_rdata_i = (reqc == lat) ? dm[ea] : 16'($urandom);
            end else begin
                bus.dmem_ack_i   = ($urandom_range(0, 3) == 0);
                bus.dmem_rdata_i = 16'($urandom);
            end
            if (bus.next_o) done = 1;
            else if (bus.be_o) stray = 1;
        end

        check("next_seen", 32'(done), 32'd1);
        check("latency", 32'(cyc), 32'(exp_lat));
        check("be", 32'(bus.be_o), 32'(exp_be));
        if (is_br) check("branch_adr", 32'(bus.branch_adr_o), 32'(rt));
        if (is_mem) check("req_cycles", 32'(reqc), 32'(lat));
        check("stray_req_be", 32'(stray), 32'd0);
        check("illegal", 32'(illegal), 32'(m_ill));
        if (wr && rd != 4'd0) mr[rd] = res;
        if (is_mem && !is_ld) dm[ea] = sd;
        dbg_raddr = rd;
        #1 check("reg_rd", 32'(dbg_rdata), 32'(mr[rd]));
        dbg_raddr = 4'($urandom);
        #1 check("reg_any", 32'(dbg_rdata), 32'(mr[dbg_raddr]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, cnt, op;
        bus.instr_i      = enc(1, 1, 0, 5);
        bus.dmem_ack_i   = 1'b0;
        bus.dmem_rdata_i = '0;
        dbg_raddr        = '0;
        m_ill            = 0;
        for (int i = 0; i < 16; i++) mr[i] = '0;
        for (int i = 0; i < 256; i++) dm[i] = 16'($urandom);
        dm[2] = 16'h00A5;

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_next", 32'(bus.next_o), 32'd0);
        check("rst_be", 32'(bus.be_o), 32'd0);
        check("rst_req", 32'(bus.dmem_req_o), 32'd0);
        check("rst_we", 32'(bus.dmem_we_o), 32'd0);
        check("rst_addr", 32'(bus.dmem_addr_o), 32'd0);
        check("rst_wdata", 32'(bus.dmem_wdata_o), 32'd0);
        check("rst_badr", 32'(bus.branch_adr_o), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        rst_n = 1'b1;

        run_instr(enc(1, 1, 0, 5), 1);
        run_instr(enc(1, 2, 0, 2), 1);
        run_instr(enc(2, 4, 1, 2), 1);
        run_instr(enc(3, 5, 1, 2), 1);
        run_instr(enc(1, 3, 0, 1), 1);
        run_instr(enc(5, 1, 3, 0), 2);
        run_instr(enc(4, 6, 3, 1), 2);
        run_instr(enc(6, 1, 4, 12), 1);
        run_instr(enc(6, 1, 1, 12), 1);
        run_instr(enc(7, 0, 0, 12), 1);
        run_instr(enc(1, 0, 0, 7), 1);
        run_instr(enc(2, 7, 0, 2), 1);
        run_instr(enc(10, 3, 3, 3), 1);
        run_instr(enc(0, 0, 0, 0), 1);

        repeat (150) begin
            op = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 14) : $urandom_range(0, 7);
            run_instr(enc(op, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15)),
                      $urandom_range(1, 4));
        end

        // Reset while a store waits for its ack.
        bus.instr_i    = enc(5, 1, 3, 0);
        bus.dmem_ack_i = 1'b0;
        cyc = 0;
        while (!bus.dmem_req_o && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("mem_entry_req", 32'(bus.dmem_req_o), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        bus.dmem_ack_i = 1'b1;
        #1 check("rst_mid_req", 32'(bus.dmem_req_o), 32'd0);
        check("rst_mid_next", 32'(bus.next_o), 32'd0);
        check("rst_mid_illegal", 32'(illegal), 32'd0);
        for (int r = 0; r < 16; r++) begin
            dbg_raddr = 4'(r);
            #1 check("rst_mid_reg", 32'(dbg_rdata), 32'd0);
        end
        for (int i = 0; i < 16; i++) mr[i] = '0;
        m_ill = 0;
        @(negedge clk);
        rst_n = 1'b1;
        run_instr(enc(0, 0, 0, 0), 1);
        run_instr(enc(1, 1, 0, 9), 1);
        run_instr(enc(2, 2, 0, 1), 3);

        bus.instr_i = enc(15, 0, 0, 0);
        cnt = 0;
        repeat (23) begin
            @(negedge clk);
            if (bus.next_o) cnt++;
        end
        check("halt_no_next", 32'(cnt), 32'd0);
        check("halted", 32'(halted), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
